// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency single-word memory responder for the MAR/MDR port
module memory_responder #(
  parameter int ADDR_BITS  = 9,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           MAR_addr,
  input  logic [DATA_WIDTH-1:0] MDR_data,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  Done,
  output logic                  Busy,
  output logic                  Error
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wr_q;
  logic                  err_q;
  logic                  accept;
  logic                  conflict;
  logic                  access;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Upper address bits alias onto the same word and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, MAR_addr[31:ADDR_BITS]};

  assign accept   = (state == S_IDLE) && (Read ^ Write);
  assign conflict = (state == S_IDLE) && Read && Write;
  assign access   = (state == S_WAIT) && (cnt == 4'd0);

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: DONE always lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_WAIT;
      S_WAIT:  if (access) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally
  always_comb begin
    Busy  = (state != S_IDLE);
    Done  = (state == S_DONE);
    Error = err_q;
  end

  // Request latch, latency counter, conflict flag and read-data register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      Mdatain <= '0;
    end else begin
      err_q <= conflict;
      if (accept) begin
        cnt    <= 4'(LATENCY - 1);
        addr_q <= MAR_addr[ADDR_BITS-1:0];
        data_q <= MDR_data;
        wr_q   <= Write;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !wr_q) Mdatain <= mem[addr_q];
    end
  end

  // Word RAM write port; contents survive clear
  always_ff @(posedge clock) begin
    if (access && wr_q) mem[addr_q] <= data_q;
  end

endmodule
